// File: rtl/path_pkg.sv
// Shared definitions for the Path priority queue: record layout, ordering codes, FSM states.
package path_pkg;

    localparam int unsigned PATH_W = 65;
    localparam int unsigned H_LSB  = 1;
    localparam int unsigned H_MSB  = 16;
    localparam int unsigned G_LSB  = 17;
    localparam int unsigned G_MSB  = 32;

    localparam logic [1:0] ORD_LT = 2'd0;
    localparam logic [1:0] ORD_EQ = 2'd1;
    localparam logic [1:0] ORD_GT = 2'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    // Total cost f = g + h, wrapping at 16 bits.
    function automatic logic [15:0] path_f(input logic [PATH_W-1:0] p);
        return p[G_MSB:G_LSB] + p[H_MSB:H_LSB];
    endfunction

endpackage

// File: rtl/path_order_cmp.sv
// Combinational Path ordering: compares f = g + h first, then g as the tiebreak.
module path_order_cmp
    import path_pkg::*;
(
    input  logic [PATH_W-1:0] a_i,
    input  logic [PATH_W-1:0] b_i,
    output logic [1:0]        ord_o
);

    logic [15:0] f_a, f_b, g_a, g_b;

    always_comb begin
        f_a   = path_f(a_i);
        f_b   = path_f(b_i);
        g_a   = a_i[G_MSB:G_LSB];
        g_b   = b_i[G_MSB:G_LSB];
        ord_o = ORD_GT;
        if (f_a != f_b) begin
            ord_o = (f_a < f_b) ? ORD_LT : ORD_GT;
        end else if (g_a == g_b) begin
            ord_o = ORD_EQ;
        end else if (g_a < g_b) begin
            ord_o = ORD_LT;
        end
    end

endmodule

// File: rtl/path_pq_ctrl.sv
// Sorted-array priority queue of Paths; inserts by scanning down from the tail one compare per
// cycle, shifting larger entries up, so entry 0 is always the minimum.
module path_pq_ctrl
    import path_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [PATH_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [PATH_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    state_e            state_q, state_d;
    logic [PATH_W-1:0] entry_q [DEPTH];
    logic [PATH_W-1:0] entry_d [DEPTH];
    logic [PATH_W-1:0] new_q, new_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  pos_q, pos_d;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic [PATH_W-1:0] cmp_b, write_val;
    logic [1:0]        ord;
    logic              push_fire, pop_fire, scan_done;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    path_order_cmp u_cmp (
        .a_i   (new_q),
        .b_i   (cmp_b),
        .ord_o (ord)
    );

    // entry[pos-1]; the value at pos == 0 is unused since that cycle always writes slot 0.
    always_comb begin
        cmp_b = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (pos_q == CNT_W'(i)) cmp_b = entry_q[i-1];
        end
    end

    assign scan_done = (pos_q == '0) || (ord != ORD_LT);
    assign write_val = scan_done ? new_q : cmp_b;

    // State register
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) state_q <= S_IDLE;
        else                  state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (push_fire) state_d = S_SCAN;
            S_SCAN: if (scan_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        push_ready = (state_q == S_IDLE) && !full;
        pop_valid  = (state_q == S_IDLE) && !empty;
        pop_data   = entry_q[0];
        push_fire  = push_valid && push_ready;
        pop_fire   = pop_valid && pop_ready;
    end

    // Datapath: pop shift, push latch, scan insert
    always_comb begin
        entry_d       = entry_q;
        new_d         = new_q;
        count_d       = count_q;
        pos_d         = pos_q;
        cnt_after_pop = pop_fire ? count_q - CNT_W'(1) : count_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop_fire) begin
                    for (int i = 0; i < DEPTH - 1; i++) entry_d[i] = entry_q[i+1];
                    entry_d[DEPTH-1] = '0;
                end
                count_d = cnt_after_pop;
                if (push_fire) begin
                    new_d = push_data;
                    pos_d = cnt_after_pop;
                end
            end
            S_SCAN: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (pos_q == CNT_W'(i)) entry_d[i] = write_val;
                end
                if (scan_done) count_d = count_q + CNT_W'(1);
                else           pos_d   = pos_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            new_q   <= '0;
            count_q <= '0;
            pos_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
            new_q   <= new_d;
            count_q <= count_d;
            pos_q   <= pos_d;
        end
    end

endmodule

// File: tb/tb_path_pq_ctrl.sv
// Scoreboard bench for path_pq_ctrl: a sorted reference queue predicts pop order and scan length.
module tb_path_pq_ctrl;
    import path_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              push_valid, push_ready, pop_valid, pop_ready, full, empty;
    logic [PATH_W-1:0] push_data, pop_data;
    logic [CNT_W-1:0]  count;

    logic [PATH_W-1:0] model [$];
    int                n_chk  = 0;
    int                n_pass = 0;

    always #5 clk = ~clk;

    path_pq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_data       (push_data),
        .pop_valid       (pop_valid),
        .pop_ready       (pop_ready),
        .pop_data        (pop_data),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [PATH_W-1:0] mk(input logic [15:0] g, input logic [15:0] h,
                                              input logic [32:0] pay);
        return {pay[32:1], g, h, pay[0]};
    endfunction

    // a strictly precedes b in queue order
    function automatic logic precedes(input logic [PATH_W-1:0] a, input logic [PATH_W-1:0] b);
        logic [15:0] fa, fb;
        fa = 16'(a[32:17] + a[16:1]);
        fb = 16'(b[32:17] + b[16:1]);
        return (fa < fb) || ((fa == fb) && (a[32:17] < b[32:17]));
    endfunction

    function automatic int ins_idx(input logic [PATH_W-1:0] p);
        for (int i = 0; i < model.size(); i++) begin
            if (precedes(p, model[i])) return i;
        end
        return model.size();
    endfunction

    // Counts SCAN cycles (pop_valid low) after a push handshake; call #1 after the edge.
    task automatic wait_scan(input int exp_cycles);
        int cyc = 0;
        @(negedge clk);
        while (!pop_valid && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_val("scan_cycles", 65'(cyc), 65'(exp_cycles));
    endtask

    // All tasks start and end at a negedge.
    task automatic do_push(input logic [15:0] g, input logic [15:0] h, input logic [32:0] pay);
        logic [PATH_W-1:0] p;
        int                idx, w;
        p   = mk(g, h, pay);
        idx = ins_idx(p);
        w   = 0;
        while (!push_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!push_ready) begin
            check_val("push_ready_wait", 65'(push_ready), 65'(1));
            return;
        end
        push_valid = 1'b1;
        push_data  = p;
        @(posedge clk);
        #1 push_valid = 1'b0;
        wait_scan(model.size() - idx + 1);
        model.insert(idx, p);
    endtask

    task automatic do_pop();
        check_val("pop_valid", 65'(pop_valid), 65'(model.size() != 0));
        if (model.size() == 0) return;
        check_val("pop_data", pop_data, model[0]);
        pop_ready = 1'b1;
        @(posedge clk);
        #1 pop_ready = 1'b0;
        void'(model.pop_front());
        @(negedge clk);
    endtask

    task automatic drain();
        while (model.size() != 0) do_pop();
        check_val("drained_empty", 65'(empty), 65'(1));
    endtask

    initial begin
        logic [PATH_W-1:0] p;
        int                idx;
        rstn       = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        push_data  = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        check_val("rst_push_ready", 65'(push_ready), 65'(1));
        check_val("rst_pop_valid", 65'(pop_valid), 65'(0));
        check_val("rst_pop_data", pop_data, 65'(0));
        check_val("rst_empty", 65'(empty), 65'(1));
        check_val("rst_full", 65'(full), 65'(0));
        check_val("rst_count", 65'(count), 65'(0));

        // Basic ordering: f = 7, 3, 5 -> pops 3, 5, 7
        do_push(16'd3, 16'd4, 33'h0_0000_0001);
        do_push(16'd1, 16'd2, 33'h1_2345_6780);
        do_push(16'd5, 16'd0, 33'h0_DEAD_BEEF);
        check_val("basic_count", 65'(count), 65'(3));
        check_val("basic_head_f", 65'(path_f(pop_data)), 65'(3));
        drain();

        // f tie broken by g; full tie keeps arrival order
        do_push(16'd4, 16'd3, 33'h0_0000_00A0);
        do_push(16'd2, 16'd5, 33'h0_0000_00B0);
        drain();
        do_push(16'd2, 16'd2, 33'h0_AAAA_AAAA);
        do_push(16'd2, 16'd2, 33'h1_BBBB_BBBB);
        drain();

        // Wrap: 0xFFFF + 2 -> f = 1
        do_push(16'd0, 16'd5, 33'h0_0000_0005);
        do_push(16'hFFFF, 16'd2, 33'h1_0000_0007);
        check_val("wrap_head_g", 65'(pop_data[32:17]), 65'(16'hFFFF));
        drain();

        // Fill in descending f; each push scans every stored entry
        for (int i = 0; i < DEPTH; i++) begin
            do_push(16'd0, 16'(80 - 10 * i), 33'($urandom));
        end
        check_val("full_flag", 65'(full), 65'(1));
        check_val("full_count", 65'(count), 65'(DEPTH));
        check_val("full_push_ready", 65'(push_ready), 65'(0));
        // Pop while full must not open the push side in the same cycle
        pop_ready = 1'b1;
        #1 check_val("full_pop_push_ready", 65'(push_ready), 65'(0));
        pop_ready = 1'b0;
        drain();

        // Same-cycle pop and push with three stored entries
        do_push(16'd10, 16'd0, 33'h0_0000_0010);
        do_push(16'd20, 16'd0, 33'h0_0000_0020);
        do_push(16'd30, 16'd0, 33'h0_0000_0030);
        check_val("pp_head", pop_data, model[0]);
        p = mk(16'd15, 16'd0, 33'h1_5555_0015);
        void'(model.pop_front());
        idx = ins_idx(p);
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        push_data  = p;
        @(posedge clk);
        #1;
        pop_ready  = 1'b0;
        push_valid = 1'b0;
        wait_scan(model.size() - idx + 1);
        model.insert(idx, p);
        check_val("pp_count", 65'(count), 65'(3));
        drain();

        // Reset during the third SCAN cycle of a 5-cycle insert
        for (int i = 1; i <= 4; i++) do_push(16'(10 * i), 16'd0, 33'($urandom));
        push_valid = 1'b1;
        push_data  = mk(16'd1, 16'd0, 33'h1_FFFF_FFFF);
        @(posedge clk);
        #1 push_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1 check_val("rst_async_count", 65'(count), 65'(0));
        model.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("rst_scan_count", 65'(count), 65'(0));
        check_val("rst_scan_empty", 65'(empty), 65'(1));
        check_val("rst_scan_pop_valid", 65'(pop_valid), 65'(0));
        check_val("rst_scan_push_ready", 65'(push_ready), 65'(1));
        check_val("rst_scan_pop_data", pop_data, 65'(0));

        // Queue still works after the abandoned insert
        do_push(16'd7, 16'd7, 33'h0_0000_0077);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
